mux4to1_16bits_rr: RTL
======================

// Module: mux4to1_16bits_rr
// PURPOSE
//   Gathers four 16-bit lanes into one registered output stream; the merge
//   point for the four-way registered split of the multiplier datapath.
//   Each lane and the output use valid/ready handshakes. A round-robin
//   arbiter picks one lane per transfer. out_sel reports the source lane,
//   so downstream logic can see where each word came from.
// PARAMETERS
//   WIDTH   16   data width of every lane and of the output
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous reset, active low
//   A,B,C,D    in   WIDTH    lane 0..3 data
//   in_valid   in   4        bit i = lane i (A=0..D=3) holds a word
//   in_ready   out  4        bit i = lane i word is accepted this cycle
//   X          out  WIDTH    registered output data
//   out_sel    out  2        source lane of X (0=A..3=D)
//   out_valid  out  1        X/out_sel hold a word
//   out_ready  in   1        consumer accepts X this cycle
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): X=0, out_sel=0, out_valid=0, ptr=0.
//     in_ready=0 while rst_n=0. Reset mid-transfer drops the held word.
//   Transfer rules:
//     lane i transfers when in_valid[i] & in_ready[i] at a posedge.
//     output transfers when out_valid & out_ready at a posedge.
//   Output is a single register stage:
//     space = ~out_valid | out_ready.
//   Grant logic (combinational from in_valid and ptr):
//     search lanes ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//     grant the first lane with in_valid set.
//     in_ready[i] = grant[i] & space & rst_n.
//     At most one in_ready bit is high. All are 0 when no lane is valid.
//   On a lane-i transfer:
//     X <= lane i data, out_sel <= i, out_valid <= 1.
//     ptr <= i+1 (wraps 3->0).
//   Output transfer with no lane transfer: out_valid <= 0.
//     X and out_sel keep their values.
//   Output and lane transfer in the same cycle: the register is replaced.
//     out_valid stays 1, giving 1 word/cycle throughput.
//   Hold: while out_valid & ~out_ready, X and out_sel are stable.
//   Latency: 1 cycle from accepted lane word to out_valid.
//   ptr changes only on lane transfers; it never advances on idle cycles.
//   Lanes must hold data and in_valid until accepted.
//     The block does not check this.
// CONFIGURATION
//   MUX4_RR_EN defined: round-robin arbitration as described above.
//   MUX4_RR_EN undefined: fixed priority, lane 0 highest and lane 3 lowest.
//     ptr is removed (treated as constant 0).
//     All other handshake and timing rules are unchanged.
// TESTING
//   1 Reset: rst_n=0 with in_valid=4'hF
//     -> in_ready=0, out_valid=0, X=0, out_sel=0.
//   2 Single lane: C=16'h1234, in_valid=4'b0100, out_ready=1
//     -> in_ready=4'b0100; next cycle X=16'h1234, out_sel=2, out_valid=1.
//   3 Round robin (RR_EN): all valid, A..D = 1,2,3,4, out_ready=1
//     -> out_sel sequence 0,1,2,3,0; X = 1,2,3,4, one word per cycle.
//   4 Backpressure: out_valid=1 (X=16'hBEEF), out_ready=0 for 3 cycles
//     -> in_ready=0 and X, out_sel stable; out_ready=1 -> next word loads
//        in the same cycle.
//   5 Fixed priority (RR_EN undefined): in_valid=4'b1001 held
//     -> lane 0 always granted; lane 3 waits until in_valid[0]=0.
//   6 Reset mid-stream: rst_n=0 while out_valid=1
//     -> next cycle out_valid=0, ptr=0; first grant after reset is lane 0.

Source files
------------

// File: rtl/mux4to1_16bits_rr.sv
// Four-lane valid/ready merge into one registered output with a source-lane tag.
// Define MUX4_RR_EN for round-robin arbitration; otherwise lane 0 has fixed highest priority.
module mux4to1_16bits_rr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] X,
    output logic [1:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned LANES = 4;

    logic [WIDTH-1:0] x_q, x_d;
    logic [1:0]       sel_q, sel_d;
    logic             vld_q, vld_d;

    logic [1:0]       base_c;
    logic [1:0]       cand_c;
    logic [1:0]       gidx_c;
    logic             any_c;
    logic [3:0]       grant_c;
    logic             space_c;
    logic             xfer_c;
    logic [WIDTH-1:0] lane_data_c;

`ifdef MUX4_RR_EN
    logic [1:0] ptr_q, ptr_d;
    assign base_c = ptr_q;
`else
    assign base_c = 2'd0;
`endif

    // First valid lane searching upward from the base lane, wrapping mod 4
    always_comb begin
        cand_c = 2'd0;
        gidx_c = 2'd0;
        any_c  = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            cand_c = base_c + 2'(k);
            if (!any_c && in_valid[cand_c]) begin
                any_c  = 1'b1;
                gidx_c = cand_c;
            end
        end
    end

    assign grant_c  = any_c ? (4'd1 << gidx_c) : 4'd0;
    assign space_c  = ~vld_q | out_ready;
    assign in_ready = grant_c & {4{space_c & rst_n}};
    assign xfer_c   = |(in_valid & in_ready);

    always_comb begin
        case (gidx_c)
            2'd0:    lane_data_c = A;
            2'd1:    lane_data_c = B;
            2'd2:    lane_data_c = C;
            default: lane_data_c = D;
        endcase
    end

    // A lane transfer replaces the output word, so a same-cycle drain keeps full rate
    always_comb begin
        x_d   = x_q;
        sel_d = sel_q;
        vld_d = vld_q;
`ifdef MUX4_RR_EN
        ptr_d = ptr_q;
`endif
        if (xfer_c) begin
            x_d   = lane_data_c;
            sel_d = gidx_c;
            vld_d = 1'b1;
`ifdef MUX4_RR_EN
            ptr_d = gidx_c + 2'd1;
`endif
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q   <= '0;
            sel_q <= 2'd0;
            vld_q <= 1'b0;
`ifdef MUX4_RR_EN
            ptr_q <= 2'd0;
`endif
        end else begin
            x_q   <= x_d;
            sel_q <= sel_d;
            vld_q <= vld_d;
`ifdef MUX4_RR_EN
            ptr_q <= ptr_d;
`endif
        end
    end

    assign X         = x_q;
    assign out_sel   = sel_q;
    assign out_valid = vld_q;

endmodule
